// File: rtl/accelerator_read_vectors.sv
// DNC read-vector stage: r(i,k) = sum_j M(j,k) * w(i,j) over a streamed (i,k,j) sequence
// of memory/weighting pairs, emitting one read-vector element per inner loop.
module accelerator_read_vectors #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned FRAC_SIZE    = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATA_SIZE-1:0] M_IN,
  input  logic [DATA_SIZE-1:0] W_IN,
  output logic [DATA_SIZE-1:0] R_OUT,
  output logic                 R_OUT_ENABLE,
  output logic                 R_OUT_I_ENABLE
);

  localparam int unsigned DW = DATA_SIZE;
  localparam int unsigned CW = CONTROL_SIZE;
  localparam int unsigned PW = 2 * DATA_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   size_r_q, size_r_d;
  logic [DW-1:0]   size_n_q, size_n_d;
  logic [DW-1:0]   size_w_q, size_w_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   j_q, j_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   r_out_q, r_out_d;
  logic            r_en_q, r_en_d;
  logic            r_i_en_q, r_i_en_d;
  logic            ready_q, ready_d;
  logic            in_ready_q, in_ready_d;

  logic [CW-1:0]   last_i, last_k, last_j;
  logic            transfer;

  // Fixed-point product: full-width signed multiply, rescale, truncate.
  logic signed [PW-1:0] m_ext, w_ext, prod_full, prod_shift;
  logic        [DW-1:0] product;

  assign m_ext      = $signed({{DW{M_IN[DW-1]}}, M_IN});
  assign w_ext      = $signed({{DW{W_IN[DW-1]}}, W_IN});
  assign prod_full  = m_ext * w_ext;
  assign prod_shift = prod_full >>> FRAC_SIZE;
  assign product    = prod_shift[DW-1:0];

  assign last_i   = CW'(size_r_q) - CW'(1);
  assign last_k   = CW'(size_w_q) - CW'(1);
  assign last_j   = CW'(size_n_q) - CW'(1);
  assign transfer = IN_VALID & in_ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      size_r_q   <= '0;
      size_n_q   <= '0;
      size_w_q   <= '0;
      i_q        <= '0;
      k_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      r_out_q    <= '0;
      r_en_q     <= 1'b0;
      r_i_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_r_q   <= size_r_d;
      size_n_q   <= size_n_d;
      size_w_q   <= size_w_d;
      i_q        <= i_d;
      k_q        <= k_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      r_out_q    <= r_out_d;
      r_en_q     <= r_en_d;
      r_i_en_q   <= r_i_en_d;
      ready_q    <= ready_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    size_r_d   = size_r_q;
    size_n_d   = size_n_q;
    size_w_d   = size_w_q;
    i_d        = i_q;
    k_d        = k_q;
    j_d        = j_q;
    acc_d      = acc_q;
    r_out_d    = r_out_q;
    r_en_d     = 1'b0;
    r_i_en_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          size_r_d = SIZE_R_IN;
          size_n_d = SIZE_N_IN;
          size_w_d = SIZE_W_IN;
          i_d      = '0;
          k_d      = '0;
          j_d      = '0;
          if ((SIZE_R_IN == '0) || (SIZE_N_IN == '0) || (SIZE_W_IN == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (transfer) begin
          acc_d = (j_q == '0) ? product : acc_q + product;
          if (j_q == last_j) begin
            state_d  = S_EMIT;
            r_out_d  = acc_d;
            r_en_d   = 1'b1;
            r_i_en_d = (k_q == last_k);
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
      S_EMIT: begin
        j_d = '0;
        if (k_q != last_k) begin
          k_d     = k_q + CW'(1);
          state_d = S_ACCUM;
        end else begin
          k_d = '0;
          if (i_q != last_i) begin
            i_d     = i_q + CW'(1);
            state_d = S_ACCUM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d    = (state_d == S_DONE);
    in_ready_d = (state_d == S_ACCUM);
  end

  assign READY          = ready_q;
  assign IN_READY       = in_ready_q;
  assign R_OUT          = r_out_q;
  assign R_OUT_ENABLE   = r_en_q;
  assign R_OUT_I_ENABLE = r_i_en_q;

endmodule

// File: tb/tb_accelerator_read_vectors.sv
// Directed bench for accelerator_read_vectors: integer runs on a 64-bit instance and a
// Q16.16 run on a 32-bit instance, with hand-computed expected read-vector elements.
module tb_accelerator_read_vectors;

  localparam int unsigned DW  = 64;
  localparam int unsigned DW4 = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, START, IN_VALID;
  logic [DW-1:0] SIZE_R_IN, SIZE_N_IN, SIZE_W_IN, M_IN, W_IN;
  logic          READY, IN_READY, R_OUT_ENABLE, R_OUT_I_ENABLE;
  logic [DW-1:0] R_OUT;

  logic           START4, IN_VALID4;
  logic [DW4-1:0] SIZE_R4, SIZE_N4, SIZE_W4, M4, W4;
  logic           READY4, IN_READY4, R_EN4, R_I_EN4;
  logic [DW4-1:0] R_OUT4;

  accelerator_read_vectors #(.DATA_SIZE(64), .CONTROL_SIZE(64), .FRAC_SIZE(0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN), .SIZE_W_IN(SIZE_W_IN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .M_IN(M_IN), .W_IN(W_IN),
    .R_OUT(R_OUT), .R_OUT_ENABLE(R_OUT_ENABLE), .R_OUT_I_ENABLE(R_OUT_I_ENABLE)
  );

  accelerator_read_vectors #(.DATA_SIZE(32), .CONTROL_SIZE(64), .FRAC_SIZE(16)) dut4 (
    .CLK(CLK), .RST(RST), .START(START4), .READY(READY4),
    .SIZE_R_IN(SIZE_R4), .SIZE_N_IN(SIZE_N4), .SIZE_W_IN(SIZE_W4),
    .IN_VALID(IN_VALID4), .IN_READY(IN_READY4), .M_IN(M4), .W_IN(W4),
    .R_OUT(R_OUT4), .R_OUT_ENABLE(R_EN4), .R_OUT_I_ENABLE(R_I_EN4)
  );

  int total = 0;
  int bad   = 0;
  int xfers = 0, strobes = 0, istrobes = 0, readies = 0;

  // Event counters sampled on the active edge (values held during the preceding cycle).
  always @(posedge CLK) begin
    if (IN_VALID && IN_READY) xfers <= xfers + 1;
    if (R_OUT_ENABLE)         strobes <= strobes + 1;
    if (R_OUT_I_ENABLE)       istrobes <= istrobes + 1;
    if (READY)                readies <= readies + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [DW-1:0] r, input logic [DW-1:0] n, input logic [DW-1:0] w);
    SIZE_R_IN = r;
    SIZE_N_IN = n;
    SIZE_W_IN = w;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Offer one pair and hold it until accepted; returns just after the accepting edge.
  task automatic send_pair(input logic [DW-1:0] m, input logic [DW-1:0] w);
    int n;
    n = 0;
    M_IN = m;
    W_IN = w;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("wait_in_ready", 64'(IN_READY), 64'(1));
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    start_run(1, 3, 1);
    check({tag, "_in_ready"}, 64'(IN_READY), 64'(1));
    send_pair(1, 2);
    send_pair(3, 4);
    send_pair(5, 6);
    check({tag, "_r_out"}, R_OUT, 64'd44);
    check({tag, "_en"}, 64'(R_OUT_ENABLE), 64'(1));
    check({tag, "_i_en"}, 64'(R_OUT_I_ENABLE), 64'(1));
    check({tag, "_ready_early"}, 64'(READY), 64'(0));
    tick();
    check({tag, "_ready"}, 64'(READY), 64'(1));
    check({tag, "_en_clear"}, 64'(R_OUT_ENABLE), 64'(0));
    check({tag, "_r_hold"}, R_OUT, 64'd44);
    tick();
    check({tag, "_ready_clear"}, 64'(READY), 64'(0));
  endtask

  logic [DW-1:0] mm [2][2];
  logic [DW-1:0] ww [2][2];
  logic [DW-1:0] exp_r [4];
  int r0, s0, x0, i0, idx;

  initial begin
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b0;
    SIZE_R_IN = '0; SIZE_N_IN = '0; SIZE_W_IN = '0; M_IN = '0; W_IN = '0;
    START4 = 1'b0; IN_VALID4 = 1'b0;
    SIZE_R4 = '0; SIZE_N4 = '0; SIZE_W4 = '0; M4 = '0; W4 = '0;
    #1;
    check("rst_ready", 64'(READY), 64'(0));
    check("rst_in_ready", 64'(IN_READY), 64'(0));
    check("rst_en", 64'(R_OUT_ENABLE), 64'(0));
    check("rst_i_en", 64'(R_OUT_I_ENABLE), 64'(0));
    check("rst_r_out", R_OUT, 64'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // T1: single row, back-to-back pairs: 1*2 + 3*4 + 5*6 = 44
    run_t1("t1");

    // T2: M(j,k) = [[1,2],[3,4]], w0 = [1,1], w1 = [2,0] -> 4, 6, 2, 4
    mm[0][0] = 1; mm[0][1] = 2; mm[1][0] = 3; mm[1][1] = 4;
    ww[0][0] = 1; ww[0][1] = 1; ww[1][0] = 2; ww[1][1] = 0;
    exp_r[0] = 4; exp_r[1] = 6; exp_r[2] = 2; exp_r[3] = 4;
    r0 = readies; s0 = strobes; i0 = istrobes;
    start_run(2, 2, 2);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) send_pair(mm[j][k], ww[i][j]);
        idx = i * 2 + k;
        check($sformatf("t2_r%0d", idx), R_OUT, exp_r[idx]);
        check($sformatf("t2_en%0d", idx), 64'(R_OUT_ENABLE), 64'(1));
        check($sformatf("t2_i_en%0d", idx), 64'(R_OUT_I_ENABLE), 64'(k == 1));
      end
    end
    tick();
    check("t2_ready", 64'(READY), 64'(1));
    tick(); tick();
    check("t2_ready_count", 64'(readies - r0), 64'(1));
    check("t2_strobe_count", 64'(strobes - s0), 64'(4));
    check("t2_i_strobe_count", 64'(istrobes - i0), 64'(2));

    // T3: T1 with an idle cycle before every pair
    x0 = xfers;
    start_run(1, 3, 1);
    IN_VALID = 1'b0; tick(); send_pair(1, 2);
    IN_VALID = 1'b0; tick(); send_pair(3, 4);
    IN_VALID = 1'b0; tick(); send_pair(5, 6);
    check("t3_r_out", R_OUT, 64'd44);
    check("t3_en", 64'(R_OUT_ENABLE), 64'(1));
    tick();
    check("t3_ready", 64'(READY), 64'(1));
    check("t3_xfers", 64'(xfers - x0), 64'(3));

    // T4: Q16.16, 0.5 * -2.0 = -1.0
    SIZE_R4 = 1; SIZE_N4 = 1; SIZE_W4 = 1;
    START4 = 1'b1; tick(); START4 = 1'b0;
    check("t4_in_ready", 64'(IN_READY4), 64'(1));
    M4 = 32'h0000_8000; W4 = 32'hFFFE_0000; IN_VALID4 = 1'b1;
    tick();
    IN_VALID4 = 1'b0;
    check("t4_en", 64'(R_EN4), 64'(1));
    check("t4_r_out", 64'(R_OUT4), 64'(32'hFFFF_0000));
    tick();
    check("t4_ready", 64'(READY4), 64'(1));

    // T5: zero-sized run completes without consuming or emitting
    r0 = readies; s0 = strobes;
    start_run(1, 0, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t5_in_ready_c%0d", c), 64'(IN_READY), 64'(0));
      tick();
    end
    check("t5_ready_count", 64'(readies - r0), 64'(1));
    check("t5_strobe_count", 64'(strobes - s0), 64'(0));
    check("t5_idle_ready", 64'(READY), 64'(0));

    // T6: reset mid-run abandons it, then a clean rerun
    r0 = readies; s0 = strobes;
    start_run(1, 3, 1);
    send_pair(1, 2);
    send_pair(3, 4);
    RST = 1'b1;
    #1;
    check("t6_rst_r_out", R_OUT, 64'd0);
    check("t6_rst_in_ready", 64'(IN_READY), 64'(0));
    check("t6_rst_en", 64'(R_OUT_ENABLE), 64'(0));
    check("t6_rst_ready", 64'(READY), 64'(0));
    tick(); tick();
    RST = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("t6_no_ready", 64'(readies - r0), 64'(0));
    check("t6_no_strobe", 64'(strobes - s0), 64'(0));
    check("t6_idle_in_ready", 64'(IN_READY), 64'(0));
    run_t1("t6_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
